// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state enums shared by alu_seq and its iterative
// multiply/divide engine, plus the muldiv opcode predicate.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SRL   = 4'd3,
    OP_SLT   = 4'd4,
    OP_SLTU  = 4'd5,
    OP_SRA   = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_muldiv(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier and
// restoring divider sharing a single 2*XLEN accumulator.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  alu_op_e           i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_acc,
  output logic [CW-1:0]     o_cnt
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_div;

  logic              w_last;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem;
  logic              w_ge;
  logic [XLEN-1:0]   w_trial;
  logic [2*XLEN-1:0] w_div_next;

  assign w_last = (r_cnt == CW'(XLEN));

  // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: the partial remainder lives in the high half; a quotient bit enters at the bottom.
  assign w_rem      = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge       = (w_rem >= {1'b0, r_b});
  assign w_trial    = w_rem[XLEN-1:0] - r_b;
  assign w_div_next = w_ge ? {w_trial, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};

  // Iteration state: load on start, step XLEN times, release busy on the finalise edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= {(2*XLEN){1'b0}};
      r_b    <= {XLEN{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_busy <= 1'b0;
      r_div  <= 1'b0;
    end else if (i_start) begin
      r_acc  <= {{XLEN{1'b0}}, i_a};
      r_b    <= i_b;
      r_cnt  <= {CW{1'b0}};
      r_busy <= 1'b1;
      r_div  <= (i_op == OP_DIVU) || (i_op == OP_REMU);
    end else if (r_busy && w_last) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_acc  <= r_div ? w_div_next : w_mul_next;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy & w_last;
  assign o_acc  = r_acc;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU with registered result and flags.
// Define ALU_SEQ_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU path.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg,
  output logic            err
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state;
  alu_state_e      w_state_nxt;
  logic            r_alive;
  alu_op_e         w_op;
  logic [SHW-1:0]  w_shamt;
  logic            w_accept;
  logic            w_op_md;
  logic [XLEN-1:0] w_sc_res;
  logic            w_sc_ill;
  logic            w_load;
  logic [XLEN-1:0] w_load_res;
  logic            w_load_err;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_neg;
  logic            r_err;

  assign w_op     = alu_op_e'(op);
  assign w_shamt  = in2[SHW-1:0];
  assign in_ready = r_alive & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

`ifdef ALU_SEQ_MULDIV_EN
  localparam int MD_CW = $clog2(XLEN) + 1;

  alu_op_e           r_md_op;
  logic              w_md_busy;
  logic              w_md_done;
  logic [2*XLEN-1:0] w_md_acc;
  logic [MD_CW-1:0]  w_md_cnt;
  logic              w_md_fin;
  logic [XLEN-1:0]   w_md_res;

  assign w_op_md  = is_muldiv(w_op);
  assign w_md_fin = w_md_busy & w_md_done & (w_md_cnt == MD_CW'(XLEN));

  alu_muldiv_iter #(
    .XLEN (XLEN),
    .CW   (MD_CW)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept & w_op_md),
    .i_op    (w_op),
    .i_a     (in1),
    .i_b     (in2),
    .o_busy  (w_md_busy),
    .o_done  (w_md_done),
    .o_acc   (w_md_acc),
    .o_cnt   (w_md_cnt)
  );

  // Remember which half of the accumulator the running op wants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_op <= OP_MUL;
    end else if (w_accept && w_op_md) begin
      r_md_op <= w_op;
    end
  end

  // High half carries MULHU product and REMU remainder; low half MUL and DIVU quotient.
  always_comb begin
    w_md_res = w_md_acc[XLEN-1:0];
    case (r_md_op)
      OP_MULHU, OP_REMU: w_md_res = w_md_acc[2*XLEN-1:XLEN];
      default:           w_md_res = w_md_acc[XLEN-1:0];
    endcase
  end
`else
  assign w_op_md = 1'b0;
`endif

  // Single-cycle datapath; anything not listed here is flagged illegal.
  always_comb begin
    w_sc_res = {XLEN{1'b0}};
    w_sc_ill = 1'b0;
    case (w_op)
      OP_ADD:  w_sc_res = in1 + in2;
      OP_SUB:  w_sc_res = in1 - in2;
      OP_SLL:  w_sc_res = in1 << w_shamt;
      OP_SRL:  w_sc_res = in1 >> w_shamt;
      OP_SLT:  w_sc_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: w_sc_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
      OP_SRA:  w_sc_res = $signed(in1) >>> w_shamt;
      OP_AND:  w_sc_res = in1 & in2;
      OP_OR:   w_sc_res = in1 | in2;
      OP_XOR:  w_sc_res = in1 ^ in2;
      default: begin
        w_sc_res = {XLEN{1'b0}};
        w_sc_ill = 1'b1;
      end
    endcase
  end

  // FSM state register; r_alive holds in_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_op_md ? ST_BUSY : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      ST_BUSY: begin
        if (w_md_fin) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
`endif
      ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_op_md ? ST_BUSY : ST_DONE;
        end else if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers load only on entry to DONE, from either the single-cycle or the muldiv path.
  always_comb begin
    w_load     = w_accept & ~w_op_md;
    w_load_res = w_sc_res;
    w_load_err = w_sc_ill;
`ifdef ALU_SEQ_MULDIV_EN
    if ((r_state == ST_BUSY) && w_md_fin) begin
      w_load     = 1'b1;
      w_load_res = w_md_res;
      w_load_err = 1'b0;
    end else begin
      w_load     = w_accept & ~w_op_md;
      w_load_res = w_sc_res;
      w_load_err = w_sc_ill;
    end
`endif
  end

  // Result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= {XLEN{1'b0}};
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_load) begin
      r_result <= w_load_res;
      r_zero   <= (w_load_res == {XLEN{1'b0}});
      r_neg    <= w_load_res[XLEN-1];
      r_err    <= w_load_err;
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed literal checks plus randomized traffic compared every
// cycle against a latency/arithmetic reference model of alu_seq.
module tb_alu_seq;

  localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  // Edges after the accept edge before out_valid is seen.
  localparam int MD_EDGES = MD ? XLEN + 1 : 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .err       (err)
  );

  function automatic void cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endfunction

  // Reference arithmetic straight from the opcode table.
  function automatic void calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r, output bit e);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    r = 32'd0;
    e = 1'b0;
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << b[4:0];
      4'd3:  r = a >> b[4:0];
      4'd4:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  r = (a < b) ? 32'd1 : 32'd0;
      4'd6:  r = $signed(a) >>> b[4:0];
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  r = a ^ b;
      4'd10: if (MD) r = prod[31:0];  else e = 1'b1;
      4'd11: if (MD) r = prod[63:32]; else e = 1'b1;
      4'd12: if (MD) r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b; else e = 1'b1;
      4'd13: if (MD) r = (b == 32'd0) ? a : a % b;             else e = 1'b1;
      default: e = 1'b1;
    endcase
  endfunction

  // Model state: what the outputs must show, plus a pending muldiv countdown.
  bit          m_alive, m_valid, m_zero, m_neg, m_err, p_err, m_acc, m_e;
  logic [31:0] m_res, p_res, m_r;
  int          m_busy;

  function automatic void post(input logic [31:0] r, input bit e);
    m_valid = 1'b1;
    m_res   = r;
    m_zero  = (r == 32'd0);
    m_neg   = r[31];
    m_err   = e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alive = 1'b0; m_valid = 1'b0; m_res = 32'd0;
      m_zero = 1'b0; m_neg = 1'b0; m_err = 1'b0; m_busy = 0;
    end else begin
      m_acc = in_valid && m_alive && (m_busy == 0) && (!m_valid || out_ready);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) post(p_res, p_err);
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_acc) begin
          calc(op, in1, in2, m_r, m_e);
          if (MD && (op >= 4'd10) && (op <= 4'd13)) begin
            p_res = m_r; p_err = m_e; m_busy = XLEN + 1;
          end else begin
            post(m_r, m_e);
          end
        end
      end
      m_alive = 1'b1;
    end
  end

  // Every-cycle comparison, well clear of both clock edges and of input updates.
  always @(negedge clk) begin
    #4;
    cmp("m_in_ready",  in_ready,  m_alive && (m_busy == 0) && (!m_valid || out_ready));
    cmp("m_out_valid", out_valid, m_valid);
    cmp("m_result",    result,    m_res);
    cmp("m_zero",      zero,      m_zero);
    cmp("m_neg",       neg,       m_neg);
    cmp("m_err",       err,       m_err);
  end

  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if (in_ready) got = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; op = 4'($urandom_range(0, 15)); in1 = $urandom; in2 = $urandom;
    cmp("send_accept", got, 1);
  endtask

  task automatic wait_out(input string nm, input int exp_edges);
    int edges;
    edges = 0;
    #1;
    while (!out_valid && edges < 200) begin
      cmp("busy_in_ready", in_ready, 0);
      @(negedge clk);
      #1;
      edges++;
    end
    cmp({nm, "_edges"}, edges, exp_edges);
  endtask

  task automatic expect_out(input string nm, input logic [31:0] r, input bit z, input bit n, input bit e);
    cmp({nm, "_valid"},  out_valid, 1);
    cmp({nm, "_result"}, result, r);
    cmp({nm, "_zero"},   zero, z);
    cmp({nm, "_neg"},    neg, n);
    cmp({nm, "_err"},    err, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    cmp("rst_in_ready", in_ready, 0);
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_result", result, 0);
    cmp("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 cmp("ready_before_edge", in_ready, 0);
    @(negedge clk);
    #1 cmp("ready_after_edge", in_ready, 1);

    send(4'd0, 32'd5, 32'd7);         wait_out("add", 0);   expect_out("add", 32'd12, 0, 0, 0);
    send(4'd1, 32'd3, 32'd5);         wait_out("sub", 0);   expect_out("sub", 32'hFFFF_FFFE, 0, 1, 0);
    send(4'd4, 32'hFFFF_FFFF, 32'd1); wait_out("slt", 0);   expect_out("slt", 32'd1, 0, 0, 0);
    send(4'd5, 32'hFFFF_FFFF, 32'd1); wait_out("sltu", 0);  expect_out("sltu", 32'd0, 1, 0, 0);
    send(4'd6, 32'h8000_0000, 32'd4); wait_out("sra", 0);   expect_out("sra", 32'hF800_0000, 0, 1, 0);

    send(4'd10, 32'h1_0000, 32'h1_0000); wait_out("mul", MD_EDGES);
    expect_out("mul", 32'd0, 1, 0, !MD);
    send(4'd11, 32'h1_0000, 32'h1_0000); wait_out("mulhu", MD_EDGES);
    expect_out("mulhu", MD ? 32'd1 : 32'd0, !MD, 0, !MD);
    send(4'd12, 32'd100, 32'd7); wait_out("divu", MD_EDGES);
    expect_out("divu", MD ? 32'd14 : 32'd0, !MD, 0, !MD);
    send(4'd13, 32'd100, 32'd7); wait_out("remu", MD_EDGES);
    expect_out("remu", MD ? 32'd2 : 32'd0, !MD, 0, !MD);
    send(4'd12, 32'd7, 32'd0); wait_out("divu0", MD_EDGES);
    expect_out("divu0", MD ? 32'hFFFF_FFFF : 32'd0, !MD, MD, !MD);
    send(4'd13, 32'd7, 32'd0); wait_out("remu0", MD_EDGES);
    expect_out("remu0", MD ? 32'd7 : 32'd0, !MD, 0, !MD);

    // Back-pressure: result must hold and new requests must wait.
    @(negedge clk);
    out_ready = 1'b0;
    send(4'd0, 32'd1, 32'd1);
    in_valid = 1'b1; op = 4'd0; in1 = 32'd9; in2 = 32'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp("hold_result", result, 32'd2);
      cmp("hold_valid", out_valid, 1);
      cmp("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 cmp("release_in_ready", in_ready, 1);
    send(4'd0, 32'd9, 32'd9); wait_out("add_after_hold", 0);
    expect_out("add_after_hold", 32'd18, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 4'($urandom_range(0, 15));
      in1       = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      in2       = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);

    // Reset in the middle of a divide.
    send(4'd12, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_in_ready", in_ready, 0);
    cmp("mid_rst_out_valid", out_valid, 0);
    cmp("mid_rst_result", result, 0);
    cmp("mid_rst_zero", zero, 0);
    cmp("mid_rst_neg", neg, 0);
    cmp("mid_rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 cmp("post_rst_ready0", in_ready, 0);
    @(negedge clk);
    #1;
    cmp("post_rst_ready1", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 cmp("no_stale_valid", out_valid, 0);
    end
    send(4'd14, 32'h1234_5678, 32'h9ABC_DEF0); wait_out("ill14", 0);
    expect_out("ill14", 32'd0, 1, 0, 1);
    send(4'd15, 32'hFFFF_FFFF, 32'd1); wait_out("ill15", 0);
    expect_out("ill15", 32'd0, 1, 0, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the RISC-V datapath, succeeding the single-cycle combinational ALU. It adds a valid/ready handshake, registered results and flags, a wider opcode set (shifts, logic, signed and unsigned compare), and iterative multiply/divide. It sits between operand fetch and writeback, and stalls upstream through `in_ready` while a multi-cycle op runs.

## Interface
- `XLEN`, default 32: operand and result width, ≥ 8 and a power of 2.
- `SHW`, default $clog2(XLEN): shift-amount width; derived, not overridden.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  block can accept a request this cycle.
- `op`  in  4  operation code, from `alu_pkg`.
- `in1`, `in2`  in  XLEN  operands.
- `out_valid`  out  1  result registers hold a valid result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  XLEN  registered result.
- `zero`  out  1  result == 0.
- `neg`  out  1  result[XLEN-1].
- `err`  out  1  illegal op, or muldiv op when compiled out.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SLT (signed).
  - 5 SLTU, 6 SRA, 7 AND, 8 OR, 9 XOR.
  - 10 MUL (low XLEN), 11 MULHU (high XLEN, unsigned).
  - 12 DIVU, 13 REMU.
  - 14–15 illegal.
- Shifts use `in2[SHW-1:0]`. Compares return 1 or 0 zero-extended. Add/sub wrap modulo 2^XLEN.
- FSM states are IDLE, BUSY and DONE.
  - IDLE to DONE: accept a single-cycle or illegal op.
  - IDLE to BUSY: accept ops 10–13.
  - BUSY to DONE: after exactly XLEN iteration cycles.
  - DONE to IDLE: on `out_ready` with no new accept.
  - DONE to DONE or BUSY: on `out_ready` with a simultaneous accept.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). A transfer happens when `in_valid & in_ready`. Operands are captured at accept; input changes afterwards are ignored.
- Multiply: unsigned shift-add over a 2·XLEN accumulator, one bit per cycle. MUL and MULHU select the low or high half.
- Divide: restoring, unsigned, one quotient bit per cycle. Divide-by-zero gives quotient all-ones and remainder = `in1`, with `err`=0.
- Illegal op: `result`=0, `zero`=1, `neg`=0, `err`=1, latency 1.
- `result`, `zero`, `neg` and `err` are updated only on entry to DONE, and held stable while `out_valid & !out_ready`.

## Timing
- Reset value of every output is 0: `in_ready`=0 while `rst_n` is low, and 1 in IDLE from the first edge after deassertion. The state register resets to IDLE.
- Single-cycle ops: accept at edge N, `out_valid`=1 after edge N (latency 1). Back-to-back throughput is 1 per cycle when `out_ready` is held at 1.
- Muldiv ops: accept at edge N, `out_valid`=1 after edge N+XLEN+1 (XLEN iterations plus one finalise edge).
- Reset asserted mid-BUSY aborts the op immediately. No result is produced after deassertion.
- `in_ready` stays 0 throughout BUSY; requests presented then are not taken.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: ops 10–13 are implemented as above and the iterative sub-module is instantiated.
- `ALU_SEQ_MULDIV_EN` undefined: ops 10–13 are treated as illegal (latency 1, `err`=1, `result`=0). The BUSY state and the sub-module are not built.

## Structure
- `alu_pkg` holds:
  - the 4-bit op enum `alu_op_e`;
  - the state enum `alu_state_e`;
  - helper predicate `is_muldiv(op)`.
- Sub-module `alu_muldiv_iter`:
  - ports: start, op, operands, busy/done, a 2·XLEN accumulator and an iteration counter;
  - shared by multiply and divide;
  - instantiated only under the macro.
- The top contains the FSM, the combinational single-cycle datapath, the result/flag registers and the handshake.

## Test plan
- ADD 5+7, SUB 3−5, `out_ready`=1 → 12 after 1 cycle; then 0xFFFFFFFE with `neg`=1 on the next cycle (back-to-back).
- SLT(0xFFFFFFFF,1) → 1; SLTU same operands → 0; SRA(0x80000000,4) → 0xF8000000.
- MUL and MULHU 0x10000×0x10000 → 0x0 (`zero`=1) and 0x1, each after 33 cycles. `in_ready`=0 during BUSY.
- DIVU 100/7 → 14; REMU → 2; DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
- Hold `out_ready`=0 for 5 cycles after ADD 1+1: `result`=2 stays stable and `in_ready`=0. Raising `out_ready` together with a new `in_valid` accepts in that same cycle.
- Assert `rst_n`=0 at cycle 10 of a DIVU: all outputs 0. After release, IDLE with `in_ready`=1 and no stale `out_valid`. Op 14 → `err`=1, `result`=0.
